// File: rtl/door_ctrl_param.sv
// door_ctrl_param: parametrised N-leaf sliding-door controller with hold timer, motion
// watchdog, lock/bolt and intrusion alarm. Optional alarm auto-clear: DOOR_ALARM_AUTOCLR_EN.
module door_ctrl_param #(
  parameter int LEAVES         = 2,
  parameter int HOLD_CYCLES    = 4,
  parameter int MOTION_TIMEOUT = 16,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int ALARM_CYCLES   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pa,
  input  logic              pp,
  input  logic              mo,
  input  logic              lk,
  input  logic [LEAVES-1:0] lim_o,
  input  logic              lim_c,
  output logic              mot_o,
  output logic              mot_c,
  output logic              bt,
  output logic              alarm,
  output logic              fault,
  output logic [2:0]        state
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int MW = $clog2(MOTION_TIMEOUT + 1);
  localparam int AW = $clog2(MAX_ATTEMPTS + 1);

  localparam logic [HW-1:0] HOLD_LOAD   = HW'(HOLD_CYCLES);
  localparam logic [MW-1:0] MOTION_LAST = MW'(MOTION_TIMEOUT - 1);
  localparam logic [AW-1:0] ATT_MAX     = AW'(MAX_ATTEMPTS);
  localparam logic [AW-1:0] ATT_PRE     = AW'(MAX_ATTEMPTS - 1);

  if (LEAVES < 1 || HOLD_CYCLES < 1 || MOTION_TIMEOUT < 2 ||
      MAX_ATTEMPTS < 1 || ALARM_CYCLES < 1) begin : g_bad_params
    $error("door_ctrl_param: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_CLOSED  = 3'd0,
    S_OPENING = 3'd1,
    S_OPEN    = 3'd2,
    S_CLOSING = 3'd3,
    S_LOCKED  = 3'd4,
    S_FAULT   = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [MW-1:0] motion_q, motion_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [AW-1:0] attempts_q, attempts_d;
  logic          alarm_q, alarm_d;
  logic          mo_q;
  logic          mo_rise;
  logic          alarm_set;

`ifdef DOOR_ALARM_AUTOCLR_EN
  localparam int TW = $clog2(ALARM_CYCLES + 1);
  localparam logic [TW-1:0] ALARM_LOAD = TW'(ALARM_CYCLES);
  logic [TW-1:0] alarm_tmr_q, alarm_tmr_d;
`endif

  assign mo_rise = mo & ~mo_q;

  always_comb begin
    state_d    = state_q;
    motion_d   = motion_q;
    hold_d     = hold_q;
    attempts_d = attempts_q;
    alarm_set  = 1'b0;

    case (state_q)
      S_CLOSED: begin
        if (pa | mo) begin
          state_d  = S_OPENING;
          motion_d = '0;
        end else if (lk) begin
          state_d = S_LOCKED;
        end
      end
      S_OPENING: begin
        if (&lim_o) begin
          state_d = S_OPEN;
          hold_d  = HOLD_LOAD;
        end else if (motion_q == MOTION_LAST) begin
          state_d = S_FAULT;
        end else begin
          motion_d = motion_q + MW'(1);
        end
      end
      S_OPEN: begin
        if (pa | pp) begin
          hold_d = HOLD_LOAD;
        end else if (hold_q == HW'(1)) begin
          state_d  = S_CLOSING;
          motion_d = '0;
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end
      S_CLOSING: begin
        // Someone in the way always reopens, even if the closed limit trips this cycle.
        if (pa | pp) begin
          state_d  = S_OPENING;
          motion_d = '0;
        end else if (lim_c) begin
          state_d = S_CLOSED;
        end else if (motion_q == MOTION_LAST) begin
          state_d = S_FAULT;
        end else begin
          motion_d = motion_q + MW'(1);
        end
      end
      S_LOCKED: begin
        if (!lk) begin
          state_d    = S_CLOSED;
          attempts_d = '0;
        end else if (mo_rise && attempts_q != ATT_MAX) begin
          attempts_d = attempts_q + AW'(1);
          alarm_set  = (attempts_q == ATT_PRE);
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase

    alarm_d = alarm_q | alarm_set;

`ifdef DOOR_ALARM_AUTOCLR_EN
    alarm_tmr_d = alarm_tmr_q;
    if (alarm_set) begin
      alarm_tmr_d = ALARM_LOAD;
    end else if (alarm_q) begin
      // Expiry also rearms the attempt counter so a fresh series is needed.
      if (alarm_tmr_q == TW'(1)) begin
        alarm_d     = 1'b0;
        attempts_d  = '0;
        alarm_tmr_d = '0;
      end else begin
        alarm_tmr_d = alarm_tmr_q - TW'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_CLOSED;
      motion_q   <= '0;
      hold_q     <= '0;
      attempts_q <= '0;
      alarm_q    <= 1'b0;
      mo_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      motion_q   <= motion_d;
      hold_q     <= hold_d;
      attempts_q <= attempts_d;
      alarm_q    <= alarm_d;
      mo_q       <= mo;
    end
  end

`ifdef DOOR_ALARM_AUTOCLR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alarm_tmr_q <= '0;
    end else begin
      alarm_tmr_q <= alarm_tmr_d;
    end
  end
`endif

  assign mot_o = (state_q == S_OPENING);
  assign mot_c = (state_q == S_CLOSING);
  assign bt    = (state_q == S_LOCKED);
  assign fault = (state_q == S_FAULT);
  assign alarm = alarm_q;
  assign state = state_q;

endmodule

// File: tb/tb_door_ctrl_param.sv
// Self-checking bench for door_ctrl_param: directed vector table, hand-written corner
// sequences, and randomized traffic against a cycle-level behavioural model.
module tb_door_ctrl_param;

  localparam int LEAVES         = 2;
  localparam int HOLD_CYCLES    = 4;
  localparam int MOTION_TIMEOUT = 16;
  localparam int MAX_ATTEMPTS   = 3;
  localparam int ALARM_CYCLES   = 8;

  logic              clk;
  logic              reset;
  logic              pa, pp, mo, lk, lim_c;
  logic [LEAVES-1:0] lim_o;
  logic              mot_o, mot_c, bt, alarm, fault;
  logic [2:0]        state;

  int checks   = 0;
  int failures = 0;

  door_ctrl_param #(
    .LEAVES(LEAVES), .HOLD_CYCLES(HOLD_CYCLES), .MOTION_TIMEOUT(MOTION_TIMEOUT),
    .MAX_ATTEMPTS(MAX_ATTEMPTS), .ALARM_CYCLES(ALARM_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .pa(pa), .pp(pp), .mo(mo), .lk(lk),
    .lim_o(lim_o), .lim_c(lim_c), .mot_o(mot_o), .mot_c(mot_c), .bt(bt),
    .alarm(alarm), .fault(fault), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: elapsed-time counters and plain integers.
  int m_state, m_travel, m_idle, m_attempts, m_alarm_age;
  bit m_alarm, m_mo_prev;

  task automatic model_reset();
    m_state = 0; m_travel = 0; m_idle = 0; m_attempts = 0;
    m_alarm_age = 0; m_alarm = 0; m_mo_prev = 0;
  endtask

  task automatic model_step();
    bit rise, set_now;
    rise    = mo && !m_mo_prev;
    set_now = 0;
    case (m_state)
      0: if (pa || mo) begin m_state = 1; m_travel = 0; end
         else if (lk) m_state = 4;
      1: begin
        m_travel++;
        if (&lim_o) begin m_state = 2; m_idle = 0; end
        else if (m_travel >= MOTION_TIMEOUT) m_state = 5;
      end
      2: if (pa || pp) m_idle = 0;
         else begin
           m_idle++;
           if (m_idle >= HOLD_CYCLES) begin m_state = 3; m_travel = 0; end
         end
      3: begin
        m_travel++;
        if (pa || pp) begin m_state = 1; m_travel = 0; end
        else if (lim_c) m_state = 0;
        else if (m_travel >= MOTION_TIMEOUT) m_state = 5;
      end
      4: if (!lk) begin m_state = 0; m_attempts = 0; end
         else if (rise && m_attempts < MAX_ATTEMPTS) begin
           m_attempts++;
           if (m_attempts == MAX_ATTEMPTS) set_now = 1;
         end
      default: m_state = 5;
    endcase
    if (set_now) begin m_alarm = 1; m_alarm_age = 0; end
`ifdef DOOR_ALARM_AUTOCLR_EN
    else if (m_alarm) begin
      m_alarm_age++;
      if (m_alarm_age == ALARM_CYCLES) begin m_alarm = 0; m_attempts = 0; end
    end
`endif
    m_mo_prev = mo;
  endtask

  function automatic logic [7:0] exp_vec(input int st, input bit al);
    logic [2:0] s;
    s = 3'(st);
    return {s, st == 1, st == 3, st == 4, al, st == 5};
  endfunction

  task automatic check_out(input string name, input logic [7:0] exp);
    logic [7:0] act;
    act = {state, mot_o, mot_c, bt, alarm, fault};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got state=%0d mot_o=%b mot_c=%b bt=%b alarm=%b fault=%b, want state=%0d mot_o=%b mot_c=%b bt=%b alarm=%b fault=%b",
               name, act[7:5], act[4], act[3], act[2], act[1], act[0],
               exp[7:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic set_in(input logic [3:0] in4, input logic [1:0] lo, input logic lc);
    {pa, pp, mo, lk} = in4;
    lim_o = lo;
    lim_c = lc;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_step();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_out("reset", exp_vec(0, 0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    set_in(4'b0000, 2'b00, 1'b0);
  endtask

  typedef struct {
    logic [3:0] in4;   // {pa, pp, mo, lk}
    logic [1:0] lo;
    logic       lc;
    logic [2:0] st;
    logic       al;
  } vec_t;

  vec_t tbl [34];

  function automatic vec_t mk(input logic [3:0] in4, input logic [1:0] lo, input logic lc,
                              input logic [2:0] st, input logic al);
    vec_t v;
    v.in4 = in4; v.lo = lo; v.lc = lc; v.st = st; v.al = al;
    return v;
  endfunction

  initial begin
    bit lock_mode;
    reset = 1'b1;
    set_in(4'b0000, 2'b00, 1'b0);
    lock_mode = 0;

    // Open/hold/close, reversal on closing, then lock with three manual attempts.
    tbl[0]  = mk(4'b1000, 2'b00, 1'b0, 3'd1, 1'b0);
    tbl[1]  = mk(4'b0000, 2'b11, 1'b0, 3'd2, 1'b0);
    tbl[2]  = mk(4'b0000, 2'b00, 1'b0, 3'd2, 1'b0);
    tbl[3]  = mk(4'b0000, 2'b00, 1'b0, 3'd2, 1'b0);
    tbl[4]  = mk(4'b0000, 2'b00, 1'b0, 3'd2, 1'b0);
    tbl[5]  = mk(4'b0000, 2'b00, 1'b0, 3'd3, 1'b0);
    tbl[6]  = mk(4'b0000, 2'b00, 1'b1, 3'd0, 1'b0);
    tbl[7]  = mk(4'b1000, 2'b00, 1'b0, 3'd1, 1'b0);
    tbl[8]  = mk(4'b0000, 2'b11, 1'b0, 3'd2, 1'b0);
    tbl[9]  = mk(4'b0100, 2'b00, 1'b0, 3'd2, 1'b0);
    tbl[10] = mk(4'b0000, 2'b00, 1'b0, 3'd2, 1'b0);
    tbl[11] = mk(4'b0000, 2'b00, 1'b0, 3'd2, 1'b0);
    tbl[12] = mk(4'b0000, 2'b00, 1'b0, 3'd2, 1'b0);
    tbl[13] = mk(4'b0000, 2'b00, 1'b0, 3'd3, 1'b0);
    tbl[14] = mk(4'b0100, 2'b00, 1'b1, 3'd1, 1'b0);
    tbl[15] = mk(4'b0000, 2'b11, 1'b0, 3'd2, 1'b0);
    tbl[16] = mk(4'b0000, 2'b00, 1'b0, 3'd2, 1'b0);
    tbl[17] = mk(4'b0000, 2'b00, 1'b0, 3'd2, 1'b0);
    tbl[18] = mk(4'b0000, 2'b00, 1'b0, 3'd2, 1'b0);
    tbl[19] = mk(4'b0000, 2'b00, 1'b0, 3'd3, 1'b0);
    tbl[20] = mk(4'b0000, 2'b00, 1'b1, 3'd0, 1'b0);
    tbl[21] = mk(4'b0001, 2'b00, 1'b0, 3'd4, 1'b0);
    tbl[22] = mk(4'b0011, 2'b00, 1'b0, 3'd4, 1'b0);
    tbl[23] = mk(4'b0011, 2'b00, 1'b0, 3'd4, 1'b0);
    tbl[24] = mk(4'b0001, 2'b00, 1'b0, 3'd4, 1'b0);
    tbl[25] = mk(4'b0011, 2'b00, 1'b0, 3'd4, 1'b0);
    tbl[26] = mk(4'b0011, 2'b00, 1'b0, 3'd4, 1'b0);
    tbl[27] = mk(4'b0001, 2'b00, 1'b0, 3'd4, 1'b0);
    tbl[28] = mk(4'b0011, 2'b00, 1'b0, 3'd4, 1'b1);
    tbl[29] = mk(4'b0011, 2'b00, 1'b0, 3'd4, 1'b1);
    tbl[30] = mk(4'b1001, 2'b00, 1'b0, 3'd4, 1'b1);
    tbl[31] = mk(4'b0101, 2'b00, 1'b0, 3'd4, 1'b1);
    tbl[32] = mk(4'b0000, 2'b00, 1'b0, 3'd0, 1'b1);
    tbl[33] = mk(4'b0000, 2'b00, 1'b0, 3'd0, 1'b1);

    do_reset();
    for (int i = 0; i < 34; i++) begin
      set_in(tbl[i].in4, tbl[i].lo, tbl[i].lc);
      tick();
      check_out($sformatf("vec%0d", i), exp_vec(int'(tbl[i].st), tbl[i].al));
    end

    // Watchdog: one leaf never reaches its limit.
    do_reset();
    set_in(4'b1000, 2'b00, 1'b0);
    tick();
    check_out("wd_enter", exp_vec(1, 0));
    set_in(4'b0000, 2'b01, 1'b0);
    for (int i = 0; i < MOTION_TIMEOUT - 1; i++) tick();
    check_out("wd_pre", exp_vec(1, 0));
    tick();
    check_out("wd_trip", exp_vec(5, 0));
    set_in(4'b1111, 2'b11, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    check_out("wd_sticky", exp_vec(5, 0));

    // Reset asserted mid-travel drops the motor without waiting for a clock.
    do_reset();
    set_in(4'b1000, 2'b00, 1'b0);
    tick();
    check_out("mid_open", exp_vec(1, 0));
    set_in(4'b0000, 2'b01, 1'b0);
    tick();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_out("async_rst", exp_vec(0, 0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    check_out("after_rst", exp_vec(0, 0));

`ifdef DOOR_ALARM_AUTOCLR_EN
    do_reset();
    set_in(4'b0001, 2'b00, 1'b0);
    tick();
    check_out("ac_lock", exp_vec(4, 0));
    for (int p = 0; p < 2; p++) begin
      set_in(4'b0011, 2'b00, 1'b0); tick(); tick();
      set_in(4'b0001, 2'b00, 1'b0); tick();
    end
    set_in(4'b0011, 2'b00, 1'b0);
    tick();
    check_out("ac_set", exp_vec(4, 1));
    set_in(4'b0001, 2'b00, 1'b0);
    for (int i = 0; i < ALARM_CYCLES - 1; i++) tick();
    check_out("ac_hold", exp_vec(4, 1));
    tick();
    check_out("ac_clear", exp_vec(4, 0));
    set_in(4'b0011, 2'b00, 1'b0);
    tick();
    check_out("ac_rearm", exp_vec(4, 0));
`endif

    // Randomized traffic and lock phases against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 249) do_reset();
      if (i % 40 == 0) lock_mode = ($urandom_range(0, 1) == 1);
      if (lock_mode) begin
        pa = ($urandom_range(0, 5) == 0);
        pp = ($urandom_range(0, 5) == 0);
        mo = ($urandom_range(0, 2) == 0);
        lk = ($urandom_range(0, 19) != 0);
        lim_c = ($urandom_range(0, 1) == 0);
      end else begin
        pa = ($urandom_range(0, 3) == 0);
        pp = ($urandom_range(0, 4) == 0);
        mo = ($urandom_range(0, 15) == 0);
        lk = ($urandom_range(0, 7) == 0);
        lim_c = ($urandom_range(0, 2) == 0);
      end
      lim_o = 2'($urandom_range(0, 3));
      tick();
      check_out("rand", exp_vec(m_state, m_alarm));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
